// File: rtl/grain_pkg.sv
// Shared widths, tap positions and feedback/filter functions for the Grain-style
// keystream core. Taps are fixed; the optional init-feedback path is selected
// in the top by macro GRAIN_INIT_FEEDBACK_EN.
package grain_pkg;

    localparam int LFSR_W = 80;
    localparam int NFSR_W = 24;
    localparam int LOAD_W = LFSR_W + NFSR_W;

    // LFSR feedback taps (indices into L)
    localparam int LFB_T0 = 0;
    localparam int LFB_T1 = 13;
    localparam int LFB_T2 = 23;
    localparam int LFB_T3 = 38;
    localparam int LFB_T4 = 51;
    localparam int LFB_T5 = 62;

    // NFSR feedback taps: linear terms, one 2-input and one 3-input product
    localparam int NFB_L0  = 0;
    localparam int NFB_N0  = 0;
    localparam int NFB_N1  = 5;
    localparam int NFB_N2  = 9;
    localparam int NFB_A0  = 3;
    localparam int NFB_A1  = 14;
    localparam int NFB_B0  = 7;
    localparam int NFB_B1  = 18;
    localparam int NFB_B2  = 21;

    // Filter taps
    localparam int F_N1  = 1;
    localparam int F_L0  = 3;
    localparam int F_L1  = 25;
    localparam int F_LA  = 45;
    localparam int F_NA  = 10;
    localparam int F_LB  = 63;
    localparam int F_NB  = 20;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] l);
        return l[LFB_T0] ^ l[LFB_T1] ^ l[LFB_T2] ^ l[LFB_T3] ^ l[LFB_T4] ^ l[LFB_T5];
    endfunction

    function automatic logic nfsr_fb(input logic [LFSR_W-1:0] l, input logic [NFSR_W-1:0] n);
        return l[NFB_L0] ^ n[NFB_N0] ^ n[NFB_N1] ^ n[NFB_N2]
             ^ (n[NFB_A0] & n[NFB_A1])
             ^ (n[NFB_B0] & n[NFB_B1] & n[NFB_B2]);
    endfunction

    function automatic logic filter_f(input logic [LFSR_W-1:0] l, input logic [NFSR_W-1:0] n);
        return n[F_N1] ^ l[F_L0] ^ l[F_L1] ^ (l[F_LA] & n[F_NA]) ^ (l[F_LB] & n[F_NB]);
    endfunction

endpackage

// File: rtl/grain_filter.sv
// Combinational nonlinear filter: keystream bit from current LFSR/NFSR state.
module grain_filter
    import grain_pkg::*;
(
    input  logic [LFSR_W-1:0] i_lin,
    input  logic [NFSR_W-1:0] i_nonlin,
    output logic              o_f
);

    // Filter output follows state with no register stage
    always_comb begin
        o_f = filter_f(i_lin, i_nonlin);
    end

endmodule

// File: rtl/grain_keystream.sv
// Grain-style keystream core: 80-bit LFSR + 24-bit NFSR, parallel load,
// one step per enabled cycle, combinational keystream bit f.
// Optional macro GRAIN_INIT_FEEDBACK_EN adds init_mode, which folds f back
// into both feedbacks (initialisation rounds).
module grain_keystream
    import grain_pkg::*;
(
    input  logic              Clk,
    input  logic              rst,
    input  logic              Par_Load,
    input  logic              shift_en,
    input  logic [LOAD_W-1:0] Par_In,
`ifdef GRAIN_INIT_FEEDBACK_EN
    input  logic              init_mode,
`endif
    output logic              f,
    output logic [LFSR_W-1:0] Linear,
    output logic [NFSR_W-1:0] NonLinear
);

    logic [LFSR_W-1:0] r_lin;
    logic [NFSR_W-1:0] r_nonlin;
    logic              w_f;
    logic              w_lfb;
    logic              w_nfb;
    logic              w_inj;

    grain_filter u_filter (
        .i_lin    (r_lin),
        .i_nonlin (r_nonlin),
        .o_f      (w_f)
    );

    // Feedback bits from pre-edge state, optionally with f injected
    always_comb begin
`ifdef GRAIN_INIT_FEEDBACK_EN
        w_inj = init_mode & w_f;
`else
        w_inj = 1'b0;
`endif
        w_lfb = lfsr_fb(r_lin) ^ w_inj;
        w_nfb = nfsr_fb(r_lin, r_nonlin) ^ w_inj;
    end

    // State update: reset > load > shift > hold; all-zero is a legal fixed point
    always_ff @(posedge Clk) begin
        if (rst) begin
            r_lin    <= '0;
            r_nonlin <= '0;
        end else if (Par_Load) begin
            r_lin    <= Par_In[LFSR_W-1:0];
            r_nonlin <= Par_In[LOAD_W-1:LFSR_W];
        end else if (shift_en) begin
            r_lin    <= {w_lfb, r_lin[LFSR_W-1:1]};
            r_nonlin <= {w_nfb, r_nonlin[NFSR_W-1:1]};
        end
    end

    // Drive outputs straight from state
    always_comb begin
        f         = w_f;
        Linear    = r_lin;
        NonLinear = r_nonlin;
    end

endmodule

// File: tb/tb_grain_keystream.sv
// Self-checking bench for grain_keystream: directed vectors plus randomized
// load/shift/reset traffic against a bit-queue reference model.
// Honours GRAIN_INIT_FEEDBACK_EN when defined.
module tb_grain_keystream;

    logic         Clk = 1'b0;
    logic         rst = 1'b0;
    logic         Par_Load = 1'b0;
    logic         shift_en = 1'b0;
    logic [103:0] Par_In = '0;
    logic         init_mode = 1'b0;
    logic         f;
    logic [79:0]  Linear;
    logic [23:0]  NonLinear;

    int checks = 0;
    int errors = 0;

    // Reference state: bit queues, index i holds state bit i
    bit mL[$];
    bit mN[$];

    grain_keystream dut (
        .Clk       (Clk),
        .rst       (rst),
        .Par_Load  (Par_Load),
        .shift_en  (shift_en),
        .Par_In    (Par_In),
`ifdef GRAIN_INIT_FEEDBACK_EN
        .init_mode (init_mode),
`endif
        .f         (f),
        .Linear    (Linear),
        .NonLinear (NonLinear)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_f();
        return mN[1] ^ mL[3] ^ mL[25] ^ (mL[45] & mN[10]) ^ (mL[63] & mN[20]);
    endfunction

    function automatic logic [79:0] ref_L();
        logic [79:0] v;
        for (int i = 0; i < 80; i++) v[i] = mL[i];
        return v;
    endfunction

    function automatic logic [23:0] ref_N();
        logic [23:0] v;
        for (int i = 0; i < 24; i++) v[i] = mN[i];
        return v;
    endfunction

    task automatic model_zero();
        mL = {};
        mN = {};
        for (int i = 0; i < 80; i++) mL.push_back(1'b0);
        for (int i = 0; i < 24; i++) mN.push_back(1'b0);
    endtask

    task automatic model_load(input logic [103:0] w);
        mL = {};
        mN = {};
        for (int i = 0; i < 80; i++) mL.push_back(w[i]);
        for (int i = 80; i < 104; i++) mN.push_back(w[i]);
    endtask

    task automatic model_shift(input bit inj_en);
        int lt[6] = '{0, 13, 23, 38, 51, 62};
        bit lfb, nfb, fv;
        fv  = ref_f();
        lfb = 1'b0;
        foreach (lt[k]) lfb ^= mL[lt[k]];
        nfb = mL[0] ^ mN[0] ^ mN[5] ^ mN[9] ^ (mN[3] & mN[14]) ^ (mN[7] & mN[18] & mN[21]);
        if (inj_en) begin
            lfb ^= fv;
            nfb ^= fv;
        end
        void'(mL.pop_front());
        mL.push_back(lfb);
        void'(mN.pop_front());
        mN.push_back(nfb);
    endtask

    // Apply current inputs to the model, clock the DUT, then compare
    task automatic step(input string tag);
        bit inj;
`ifdef GRAIN_INIT_FEEDBACK_EN
        inj = init_mode;
`else
        inj = 1'b0;
`endif
        if (rst) model_zero();
        else if (Par_Load) model_load(Par_In);
        else if (shift_en) model_shift(inj);
        @(posedge Clk);
        #1;
        chk({tag, "_L"}, Linear, ref_L());
        chk({tag, "_N"}, {56'h0, NonLinear}, {56'h0, ref_N()});
        chk({tag, "_f"}, {79'h0, f}, {79'h0, ref_f()});
    endtask

    localparam logic [103:0] VEC2 = 104'h123456_AAAAAAAAAAAAAAAAAAAA;

    initial begin
        model_zero();
        @(negedge Clk);

        // Reset beats load
        rst = 1; Par_Load = 1; Par_In = VEC2;
        step("rst");
        chk("rst_L0", Linear, 80'h0);
        chk("rst_N0", {56'h0, NonLinear}, 80'h0);
        chk("rst_f0", {79'h0, f}, 80'h0);

        // Load
        rst = 0; Par_Load = 1; shift_en = 0; Par_In = VEC2;
        step("load");
        chk("load_L", Linear, 80'hAAAA_AAAA_AAAA_AAAA_AAAA);
        chk("load_N", {56'h0, NonLinear}, {56'h0, 24'h123456});
        chk("load_f", {79'h0, f}, 80'h1);

`ifdef GRAIN_INIT_FEEDBACK_EN
        // Init-mode shift from the loaded state
        Par_Load = 0; shift_en = 1; init_mode = 1;
        step("init");
        chk("init_L", Linear, 80'h5555_5555_5555_5555_5555);
        chk("init_N", {56'h0, NonLinear}, {56'h0, 24'h891A2B});
        init_mode = 0;
        Par_Load = 1; shift_en = 0; Par_In = VEC2;
        step("reload");
`endif

        // One normal shift
        Par_Load = 0; shift_en = 1;
        step("shift1");
        chk("shift1_L", Linear, 80'hD555_5555_5555_5555_5555);
        chk("shift1_N", {56'h0, NonLinear}, {56'h0, 24'h091A2B});

        // Load wins over shift, then hold
        Par_Load = 1; shift_en = 1; Par_In = VEC2;
        step("prio");
        chk("prio_L", Linear, 80'hAAAA_AAAA_AAAA_AAAA_AAAA);
        chk("prio_N", {56'h0, NonLinear}, {56'h0, 24'h123456});
        Par_Load = 0; shift_en = 0;
        for (int i = 0; i < 3; i++) begin
            step("hold");
            chk("hold_L", Linear, 80'hAAAA_AAAA_AAAA_AAAA_AAAA);
            chk("hold_N", {56'h0, NonLinear}, {56'h0, 24'h123456});
        end

        // Zero fixed point
        rst = 1;
        step("zrst");
        rst = 0; shift_en = 1;
        for (int i = 0; i < 10; i++) begin
            step("zero");
            chk("zero_L", Linear, 80'h0);
            chk("zero_N", {56'h0, NonLinear}, 80'h0);
            chk("zero_f", {79'h0, f}, 80'h0);
        end

        // Mid-stream reset after a load and a few shifts
        Par_Load = 1; Par_In = VEC2;
        step("mid_ld");
        Par_Load = 0;
        step("mid_sh");
        step("mid_sh");
        rst = 1; Par_Load = 1; shift_en = 1;
        step("mid_rst");
        chk("mid_rst_L", Linear, 80'h0);
        chk("mid_rst_N", {56'h0, NonLinear}, 80'h0);
        rst = 0; Par_Load = 0; shift_en = 0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [127:0] r;
            r = {$urandom, $urandom, $urandom, $urandom};
            Par_In   = r[103:0];
            rst      = ($urandom_range(0, 39) == 0);
            Par_Load = ($urandom_range(0, 9) == 0);
            shift_en = ($urandom_range(0, 3) != 0);
            init_mode = $urandom_range(0, 1);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
